// File: rtl/value_line_pkg.sv
// Shared width-derivation helpers for the valid-qualified delay line.
// Width helpers take the depth as an argument so each instance derives its own tap/occupancy widths.
package value_line_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A single-stage line still needs a 1-bit tap select port.
  function automatic int tap_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic int occ_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/value_line_stage.sv
// One {valid,data} register of the delay line: async reset, flush clears only
// the valid bit, stall holds both.
module value_line_stage #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/value_delay_line.sv
// Stallable, flushable valid-qualified delay line with a runtime output tap
// and an occupancy counter that tracks the number of valid stages.
module value_delay_line
  import value_line_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int TAPW = tap_width(DEPTH),
  localparam int OCCW = occ_width(DEPTH)
) (
  input  logic             sys_clock,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  input  logic [TAPW-1:0]  tap_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OCCW-1:0]  occ,
  output logic             full,
  output logic             empty
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  logic             vld      [DEPTH];
  logic [WIDTH-1:0] dat      [DEPTH];
  logic             feed_vld [DEPTH];
  logic [WIDTH-1:0] feed_dat [DEPTH];
  logic [OCCW-1:0]  occ_q;
  stage_t           tap;

  // Stage chain: stage 0 takes the input port, stage k takes stage k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign feed_vld[k] = in_valid;
      assign feed_dat[k] = in_data;
    end else begin : g_body
      assign feed_vld[k] = vld[k-1];
      assign feed_dat[k] = dat[k-1];
    end

    value_line_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (sys_clock),
      .rst       (sys_rst),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (feed_vld[k]),
      .in_data   (feed_dat[k]),
      .out_valid (vld[k]),
      .out_data  (dat[k])
    );
  end

  // Occupancy: a sample enters with in_valid and leaves from the last stage.
  always_ff @(posedge sys_clock or posedge sys_rst) begin
    if (sys_rst) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (!stall) begin
      occ_q <= occ_q + OCCW'(in_valid) - OCCW'(vld[DEPTH-1]);
    end
  end

  // Tap indices beyond the last stage never match and fall back to it.
  always_comb begin
    tap = '{valid: vld[DEPTH-1], data: dat[DEPTH-1]};
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel == TAPW'(k)) tap = '{valid: vld[k], data: dat[k]};
    end
  end

  assign out_valid = tap.valid;
  assign out_data  = tap.data;
  assign occ       = occ_q;
  assign full      = (occ_q == OCCW'(DEPTH));
  assign empty     = (occ_q == '0);

endmodule

// File: tb/tb_value_delay_line.sv
// Directed bench for value_delay_line: stimulus pushes expected (cycle, data)
// entries, a negedge monitor pops and compares whenever out_valid is high.
module tb_value_delay_line;

  typedef struct {
    int         cyc;
    logic [1:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, stall, flush;
  logic [1:0] in_data, tap_sel;
  logic       out_valid, full, empty;
  logic [1:0] out_data;
  logic [2:0] occ;

  logic       in_valid3, stall3, flush3;
  logic [1:0] in_data3, tap_sel3;
  logic       out_valid3, full3, empty3;
  logic [1:0] out_data3;
  logic [1:0] occ3;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  value_delay_line #(.WIDTH(2), .DEPTH(4)) dut (
    .sys_clock (clk),
    .sys_rst   (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .stall     (stall),
    .flush     (flush),
    .tap_sel   (tap_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occ       (occ),
    .full      (full),
    .empty     (empty)
  );

  value_delay_line #(.WIDTH(2), .DEPTH(3)) dut3 (
    .sys_clock (clk),
    .sys_rst   (rst),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .stall     (stall3),
    .flush     (flush3),
    .tap_sel   (tap_sel3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .occ       (occ3),
    .full      (full3),
    .empty     (empty3)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input logic iv, input logic [1:0] d, input logic st, input logic fl);
    in_valid = iv;
    in_data  = d;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares data and arrival cycle of each valid output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got data %0d at cycle %0d, expected no valid output", out_data, cyc);
        end else begin
          e = q.pop_front();
          chk("out_data", int'(out_data), int'(e.data));
          chk("out_cycle", cyc, e.cyc);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_valid: got no output at cycle %0d, expected data %0d", cyc, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int occ_s1 [7] = '{1, 2, 3, 3, 2, 1, 0};
    logic       iv_s2 [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [1:0] d_s2  [9] = '{1, 2, 0, 0, 3, 0, 0, 0, 0};
    logic       st_s2 [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    int         occ_s2[9] = '{1, 2, 2, 2, 3, 3, 2, 1, 0};
    logic       iv_s3 [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [1:0] d_s3  [8] = '{1, 2, 3, 2, 0, 0, 0, 0};
    logic       fl_s3 [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int         occ_s3[8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    int occ_s4 [12] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    int full_s4[12] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int occ_s5 [4] = '{1, 1, 1, 0};

    rst = 1'b1;
    in_valid = 1'b0; in_data = 2'd0; stall = 1'b0; flush = 1'b0; tap_sel = 2'd3;
    in_valid3 = 1'b0; in_data3 = 2'd0; stall3 = 1'b0; flush3 = 1'b0; tap_sel3 = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_occ", int'(occ), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Fill and drain on tap 3
    c0 = cyc;
    q.push_back('{c0 + 4, 2'd1});
    q.push_back('{c0 + 5, 2'd2});
    q.push_back('{c0 + 6, 2'd3});
    for (int i = 0; i < 7; i++) begin
      tick(i < 3, 2'(i + 1), 1'b0, 1'b0);
      chk("s1_occ", int'(occ), occ_s1[i]);
    end
    chk("s1_empty", int'(empty), 1);

    // Two-cycle stall after the second sample
    c0 = cyc;
    q.push_back('{c0 + 6, 2'd1});
    q.push_back('{c0 + 7, 2'd2});
    q.push_back('{c0 + 8, 2'd3});
    for (int i = 0; i < 9; i++) begin
      tick(iv_s2[i], d_s2[i], st_s2[i], 1'b0);
      chk("s2_occ", int'(occ), occ_s2[i]);
    end

    // Flush together with a valid input and a stall
    for (int i = 0; i < 8; i++) begin
      tick(iv_s3[i], d_s3[i], fl_s3[i], fl_s3[i]);
      chk("s3_occ", int'(occ), occ_s3[i]);
      if (i >= 3) begin
        chk("s3_empty", int'(empty), 1);
        chk("s3_out_valid", int'(out_valid), 0);
      end
    end

    // Saturation, then drain
    c0 = cyc;
    for (int i = 0; i < 8; i++) q.push_back('{c0 + 4 + i, 2'(i)});
    for (int i = 0; i < 12; i++) begin
      tick(i < 8, 2'(i), 1'b0, 1'b0);
      chk("s4_occ", int'(occ), occ_s4[i]);
      chk("s4_full", int'(full), full_s4[i]);
    end

    // Asynchronous reset mid-stream, observed on tap 0
    tap_sel = 2'd0;
    c0 = cyc;
    q.push_back('{c0 + 1, 2'd1});
    q.push_back('{c0 + 2, 2'd2});
    q.push_back('{c0 + 3, 2'd3});
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'(i + 1), 1'b0, 1'b0);
      chk("s5_occ_fill", int'(occ), i + 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("s5_rst_out_valid", int'(out_valid), 0);
    chk("s5_rst_out_data", int'(out_data), 0);
    chk("s5_rst_occ", int'(occ), 0);
    chk("s5_rst_empty", int'(empty), 1);
    chk("s5_rst_full", int'(full), 0);
    #1;
    rst = 1'b0;
    q.push_back('{cyc + 1, 2'd2});
    tick(1'b1, 2'd2, 1'b0, 1'b0);
    chk("s5_tap0_valid", int'(out_valid), 1);
    chk("s5_tap0_data", int'(out_data), 2);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'd0, 1'b0, 1'b0);
      chk("s5_occ_drain", int'(occ), occ_s5[i]);
    end
    tap_sel = 2'd3;

    // DEPTH=3: clamped tap and live tap switching
    for (int i = 0; i < 3; i++) begin
      in_valid3 = 1'b1;
      in_data3  = 2'(i + 1);
      tick(1'b0, 2'd0, 1'b0, 1'b0);
      if (i == 0) chk("s6_clamp_empty", int'(out_valid3), 0);
    end
    in_valid3 = 1'b0;
    chk("s6_clamp_valid", int'(out_valid3), 1);
    chk("s6_clamp_data", int'(out_data3), 1);
    chk("s6_occ", int'(occ3), 3);
    chk("s6_full", int'(full3), 1);
    tap_sel3 = 2'd2;
    #1;
    chk("s6_tap2_data", int'(out_data3), 1);
    tap_sel3 = 2'd0;
    #1;
    chk("s6_tap0_data", int'(out_data3), 3);
    tap_sel3 = 2'd1;
    #1;
    chk("s6_tap1_data", int'(out_data3), 2);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
